chunked_serial_adder: RTL
=========================

CHUNKED_SERIAL_ADDER -- requirements
Module: chunked_serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, giving the bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1): the operand handshake.
REQ-006 The block SHALL have ports in1 and in2 (input, WIDTH) and cin (input, 1): the operands and carry-in.
REQ-007 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1): the result handshake.
REQ-008 The block SHALL have ports sum (output, WIDTH) and cout (output, 1): the registered result.
REQ-009 The block SHALL have port ovf (output, 1), present only when SIGNED_OVF_EN is defined: the signed-overflow flag.

Function
REQ-010 An operand transfer SHALL occur on a clk edge with in_valid && in_ready; in1, in2 and cin SHALL be captured into internal registers.
REQ-011 The FSM SHALL have states IDLE, ADD and DONE: IDLE->ADD on transfer; ADD->DONE after N = WIDTH/CHUNK chunk cycles; DONE->IDLE on out_valid && out_ready.
REQ-012 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-013 In ADD, each cycle SHALL add one CHUNK-bit slice, LSB slice first, with carry from the previous slice (cin for slice 0), and write that slice of sum.
REQ-014 The chunk index counter SHALL count 0..N-1 and clear on entry to ADD; there SHALL be no wrap inside an operation.
REQ-015 Latency SHALL be N+1 cycles from the transfer edge to out_valid high, i.e. 5 cycles at the defaults.
REQ-016 cout SHALL equal the carry out of bit WIDTH-1; {cout,sum} SHALL equal in1+in2+cin exactly (mod 2^(WIDTH+1)).
REQ-017 sum, cout and ovf SHALL hold stable while out_valid=1 && out_ready=0, for any number of cycles.
REQ-018 Inputs presented while in_ready=0 SHALL be ignored; there SHALL be no pass-through from DONE to ADD in the same cycle, and the next transfer is accepted at the earliest one cycle after the result handshake.
REQ-019 When N=1 (CHUNK=WIDTH), the block SHALL spend one ADD cycle, giving a latency of 2.

Reset
REQ-020 When rst=1 at a clk edge, the block SHALL go to IDLE and clear in_ready-related state, sum=0, cout=0, ovf=0 and the counter, with out_valid=0 and in_ready=1 on the next cycle.
REQ-021 Reset asserted in ADD or DONE SHALL abort the operation; no partial result SHALL be presented afterwards.
REQ-022 rst SHALL take priority over every handshake event in the same cycle.

Configuration
REQ-023 Macro SIGNED_OVF_EN: when defined, the block SHALL have the ovf port, ovf = carry into MSB XOR carry out of MSB, registered with the final slice and valid in DONE.
REQ-024 Without SIGNED_OVF_EN, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-025 A shared package adder_pkg SHALL hold the FSM state typedef (IDLE, ADD, DONE) and the default WIDTH and CHUNK constants.
REQ-026 The per-slice adder SHALL be a sub-module rca_chunk (parameter CHUNK; inputs a, b, ci; outputs s, co), built as a combinational ripple of full adders and instantiated once.
REQ-027 An elaboration-time check SHALL fail if WIDTH % CHUNK != 0.

Verification
REQ-028 Basic add: in1=53742381, in2=78236893, cin=0 -> sum=131979274, cout=0, out_valid exactly 5 cycles after the transfer.
REQ-029 Carry-in: in1=53742381, in2=7823689, cin=1 -> sum=61566071, cout=0.
REQ-030 Full carry ripple: in1=4294963215, in2=4081, cin=0 -> sum=0, cout=1; same operands with cin=1 -> sum=1, cout=1; in2=4086 with cin=1 -> sum=6, cout=1.
REQ-031 Backpressure: hold out_ready=0 for 10 cycles in DONE -> sum and cout stable, in_ready=0, and in_valid pulses ignored; release -> IDLE next cycle.
REQ-032 Reset mid-ADD: assert rst at chunk 2 -> next cycle out_valid=0, sum=0, in_ready=1; a following add of 1+1 -> sum=2.
REQ-033 With SIGNED_OVF_EN: 0x7FFFFFFF+1 -> sum=0x80000000, ovf=1, cout=0; 0xFFFFFFFF+1 -> sum=0, ovf=0, cout=1; repeat REQ-028 with CHUNK=32 and CHUNK=4 -> latency 2 and 9 respectively.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the chunked serial adder: FSM states and default sizing.
package adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_CHUNK = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rca_chunk.sv
// One CHUNK-bit ripple-carry slice built from full adders (purely combinational).
module rca_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  // Full-adder chain, carry rippling from bit 0 upward
  for (genvar i = 0; i < int'(CHUNK); i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[CHUNK];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: captures two WIDTH-bit operands plus carry-in, adds one
// CHUNK-bit slice per cycle (LSB first) and presents {cout,sum} with a
// valid/ready handshake. Define SIGNED_OVF_EN to add the signed-overflow
// output ovf.
module chunked_serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  // Operand width must split into whole slices
  if ((WIDTH % CHUNK) != 0) begin : g_width_check
    $error("chunked_serial_adder: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [IDX_W-1:0] idx;

  logic [CHUNK-1:0] sl_a_c;
  logic [CHUNK-1:0] sl_b_c;
  logic [CHUNK-1:0] sl_s_c;
  logic             sl_co_c;
  logic             take_c;
  logic             give_c;
  logic             last_c;

  assign take_c = in_valid && in_ready;
  assign give_c = out_valid && out_ready;
  assign last_c = (idx == LAST_IDX);

  // Select the operand slices addressed by the chunk index
  always_comb begin
    sl_a_c = '0;
    sl_b_c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx == IDX_W'(k)) begin
        sl_a_c = op_a[k*CHUNK +: CHUNK];
        sl_b_c = op_b[k*CHUNK +: CHUNK];
      end
    end
  end

  rca_chunk #(
    .CHUNK (CHUNK)
  ) u_rca (
    .a  (sl_a_c),
    .b  (sl_b_c),
    .ci (carry),
    .s  (sl_s_c),
    .co (sl_co_c)
  );

`ifdef SIGNED_OVF_EN
  logic msb_ci_c;
  // Carry into the top bit of the slice, recovered from its sum bit
  assign msb_ci_c = sl_a_c[CHUNK-1] ^ sl_b_c[CHUNK-1] ^ sl_s_c[CHUNK-1];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (take_c) next_state = ADD;
      ADD:     if (last_c) next_state = DONE;
      DONE:    if (give_c) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake flags registered alongside the state they decode
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (next_state == IDLE);
      out_valid <= (next_state == DONE);
    end
  end

  // Operand capture, per-slice accumulation and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SIGNED_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (take_c) begin
            op_a  <= in1;
            op_b  <= in2;
            carry <= cin;
            idx   <= '0;
          end
        end
        ADD: begin
          for (int unsigned k = 0; k < N; k++) begin
            if (idx == IDX_W'(k)) sum[k*CHUNK +: CHUNK] <= sl_s_c;
          end
          carry <= sl_co_c;
          if (last_c) begin
            cout <= sl_co_c;
`ifdef SIGNED_OVF_EN
            ovf  <= msb_ci_c ^ sl_co_c;
`endif
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
